// File: rtl/fns_pkg.sv
// Shared types and constant Fibonacci helpers for the sequential FNS/DPS codeword decoder.
package fns_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic longint fns(input int k);
    longint a;
    longint b;
    longint t;
    a = 1;
    b = 1;
    for (int i = 3; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Largest decodable value: every weight summed, with the DPS bit counted twice.
  function automatic longint dps_max(input int n, input int dps_en);
    longint s;
    s = 0;
    for (int i = 1; i <= n; i++) s += fns(i);
    if (dps_en != 0) s += fns(n - 1);
    return s;
  endfunction

endpackage

// File: rtl/fns_step.sv
// One decode step: sums P code bits against successive Fibonacci weights and advances the weight pair.
module fns_step
  import fns_pkg::*;
#(
  parameter int N      = 20,
  parameter int P      = 1,
  parameter int DPS_EN = 1,
  parameter int DW     = 15,
  parameter int IW     = 5
) (
  input  logic [P-1:0]  bits,
  input  logic [DW:0]   fa,
  input  logic [DW:0]   fb,
  input  logic [IW-1:0] base_idx,
  output logic [DW-1:0] psum,
  output logic [DW:0]   fa_nx,
  output logic [DW:0]   fb_nx,
  output logic          cy
);

  // Bit DW is a sticky "true value no longer fits" flag; the low DW bits stay exact modulo 2^DW.
  function automatic logic [DW:0] sadd(input logic [DW:0] a, input logic [DW:0] b);
    logic [DW:0] s;
    s = {1'b0, a[DW-1:0]} + {1'b0, b[DW-1:0]};
    return {a[DW] | b[DW] | s[DW], s[DW-1:0]};
  endfunction

  function automatic logic [DW:0] sdbl(input logic [DW:0] w);
    return {w[DW] | w[DW-1], w[DW-2:0], 1'b0};
  endfunction

  logic [DW:0]   wa;
  logic [DW:0]   wb;
  logic [DW:0]   w;
  logic [DW:0]   acc_s;
  logic [IW-1:0] idx;

  always_comb begin
    wa    = fa;
    wb    = fb;
    w     = '0;
    acc_s = '0;
    idx   = '0;
    for (int j = 0; j < P; j++) begin
      idx = base_idx + IW'(j);
      w   = wa;
      if (DPS_EN != 0 && idx == IW'(N - 2)) w = sdbl(wa);
      if (bits[j]) acc_s = sadd(acc_s, w);
      w  = sadd(wa, wb);
      wa = wb;
      wb = w;
    end
    psum  = acc_s[DW-1:0];
    cy    = acc_s[DW];
    fa_nx = wa;
    fb_nx = wb;
  end

endmodule

// File: rtl/fns_dps_dec_seq.sv
// Sequential FNS/DPS codeword decoder: P bits per clock, valid/ready on both sides, weights generated on the fly.
module fns_dps_dec_seq
  import fns_pkg::*;
#(
  parameter int N      = 20,
  parameter int P      = 1,
  parameter int DPS_EN = 1,
  parameter int DW     = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  codein,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          ovf
);

  localparam int S  = (N + P - 1) / P;
  localparam int SP = S * P;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam int IW = $clog2(SP + 1);

  if (DW < $clog2(dps_max(N, DPS_EN) + 1)) begin : g_dw_chk
    $warning("fns_dps_dec_seq: DW too narrow for the full decode range, dataout will wrap");
  end

  function automatic logic [DW:0] sadd(input logic [DW:0] a, input logic [DW:0] b);
    logic [DW:0] s;
    s = {1'b0, a[DW-1:0]} + {1'b0, b[DW-1:0]};
    return {a[DW] | b[DW] | s[DW], s[DW-1:0]};
  endfunction

  state_t        state;
  state_t        state_nx;
  logic [SP-1:0] sr;
  logic [DW:0]   acc;
  logic [DW:0]   acc_nx;
  logic [DW:0]   fa;
  logic [DW:0]   fb;
  logic [DW:0]   fa_nx;
  logic [DW:0]   fb_nx;
  logic [DW-1:0] psum;
  logic          step_cy;
  logic          ovf_r;
  logic [CW-1:0] cnt;
  logic [IW-1:0] bidx;
  logic          accept;
  logic          last;

  assign accept = in_valid & in_ready;
  assign last   = (state == RUN) && (cnt == CW'(S - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  fns_step #(
    .N(N), .P(P), .DPS_EN(DPS_EN), .DW(DW), .IW(IW)
  ) u_step (
    .bits     (sr[P-1:0]),
    .fa       (fa),
    .fb       (fb),
    .base_idx (bidx),
    .psum     (psum),
    .fa_nx    (fa_nx),
    .fb_nx    (fb_nx),
    .cy       (step_cy)
  );

  assign acc_nx = sadd(acc, {step_cy, psum});

  // Accept loads the padded word and restarts the weights at (F1,F2); RUN consumes P bits per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      acc   <= '0;
      ovf_r <= 1'b0;
      fa    <= '0;
      fb    <= '0;
      cnt   <= '0;
      bidx  <= '0;
    end else if (accept) begin
      sr    <= SP'(codein);
      acc   <= '0;
      ovf_r <= 1'b0;
      fa    <= (DW+1)'(1);
      fb    <= (DW+1)'(1);
      cnt   <= '0;
      bidx  <= '0;
    end else if (state == RUN) begin
      sr    <= sr >> P;
      acc   <= acc_nx;
      ovf_r <= acc_nx[DW];
      fa    <= fa_nx;
      fb    <= fb_nx;
      cnt   <= cnt + CW'(1);
      bidx  <= bidx + IW'(P);
    end
  end

  assign dataout = acc[DW-1:0];
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_fns_dps_dec_seq.sv
// Randomized bench for fns_dps_dec_seq: four configurations checked against an arithmetic Fibonacci-sum model.
module tb_fns_dps_dec_seq;

  localparam int DPSA[4] = '{1, 0, 1, 1};
  localparam int DWA[4]  = '{15, 15, 15, 14};
  localparam int SS[4]   = '{20, 20, 5, 7};

  logic        clk;
  logic        rst;
  logic        iv   [4];
  logic        ir   [4];
  logic [19:0] cw   [4];
  logic        ov   [4];
  logic        ordy [4];
  logic [14:0] dout [4];
  logic        of   [4];
  logic [13:0] dout14;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fns_dps_dec_seq #(.N(20), .P(1), .DPS_EN(1), .DW(15)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .codein(cw[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .dataout(dout[0]), .ovf(of[0]));

  fns_dps_dec_seq #(.N(20), .P(1), .DPS_EN(0), .DW(15)) u_fns (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .codein(cw[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .dataout(dout[1]), .ovf(of[1]));

  fns_dps_dec_seq #(.N(20), .P(4), .DPS_EN(1), .DW(15)) u_p4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .codein(cw[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .dataout(dout[2]), .ovf(of[2]));

  fns_dps_dec_seq #(.N(20), .P(3), .DPS_EN(1), .DW(14)) u_dw14 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .codein(cw[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .dataout(dout14), .ovf(of[3]));

  assign dout[3] = {1'b0, dout14};

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_sum(input logic [19:0] c, input int dps);
    longint f[1:21];
    longint s;
    f[1] = 1;
    f[2] = 1;
    for (int k = 3; k <= 21; k++) f[k] = f[k-1] + f[k-2];
    s = 0;
    for (int i = 0; i < 20; i++)
      if (c[i]) s += (dps != 0 && i == 18) ? 2 * f[i+1] : f[i+1];
    return s;
  endfunction

  task automatic xfer(input int k, input logic [19:0] code, input longint exp_d,
                      input longint exp_o, input int bp);
    int n;
    int lat;
    @(negedge clk);
    iv[k]   = 1'b1;
    cw[k]   = code;
    ordy[k] = 1'b0;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", longint'(ir[k]), 1);
    @(posedge clk);
    #1;
    // Busy source keeps offering junk; it must be ignored.
    cw[k] = 20'($urandom);
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", longint'(lat), longint'(SS[k]));
    chk("dataout", longint'(dout[k]), exp_d);
    chk("ovf", longint'(of[k]), exp_o);
    for (int i = 0; i < bp; i++) begin
      cw[k] = 20'($urandom);
      @(posedge clk);
      #1;
      chk("bp_valid", longint'(ov[k]), 1);
      chk("bp_data", longint'(dout[k]), exp_d);
      chk("bp_ovf", longint'(of[k]), exp_o);
      chk("bp_in_ready", longint'(ir[k]), 0);
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    chk("consumed", longint'(ov[k]), 0);
  endtask

  task automatic xfer_rand(input int k, input logic [19:0] code, input int bp);
    longint s;
    longint m;
    s = ref_sum(code, DPSA[k]);
    m = longint'(1) << DWA[k];
    xfer(k, code, s % m, (s >= m) ? 1 : 0, bp);
  endtask

  task automatic back_to_back();
    logic [19:0] words [5];
    longint      expv  [5];
    int idx;
    int got;
    int last;
    for (int i = 0; i < 5; i++) begin
      words[i] = 20'($urandom);
      expv[i]  = ref_sum(words[i], 1) % 32768;
    end
    idx  = 0;
    got  = 0;
    last = -1;
    ordy[2] = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
      @(negedge clk);
      if (ov[2]) begin
        chk("b2b_data", longint'(dout[2]), expv[got]);
        if (last >= 0) chk("b2b_interval", longint'(cyc - last), 6);
        last = cyc;
        got++;
      end
      if (idx < 5) begin
        iv[2] = 1'b1;
        cw[2] = words[idx];
        if (ir[2]) idx++;
      end else begin
        iv[2] = 1'b0;
      end
    end
    chk("b2b_count", longint'(got), 5);
    @(negedge clk);
    iv[2]   = 1'b0;
    ordy[2] = 1'b0;
  endtask

  task automatic mid_reset();
    int stale;
    @(negedge clk);
    iv[0] = 1'b1;
    cw[0] = 20'hFFFFF;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", longint'(ir[0]), 1);
    chk("rst_out_valid", longint'(ov[0]), 0);
    chk("rst_dataout", longint'(dout[0]), 0);
    chk("rst_ovf", longint'(of[0]), 0);
    ordy[0] = 1'b1;
    stale = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ov[0]) stale++;
    end
    ordy[0] = 1'b0;
    chk("rst_stale", longint'(stale), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv[k]   = 1'b0;
      cw[k]   = '0;
      ordy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("reset_in_ready", longint'(ir[k]), 1);
      chk("reset_out_valid", longint'(ov[k]), 0);
      chk("reset_dataout", longint'(dout[k]), 0);
      chk("reset_ovf", longint'(of[k]), 0);
    end

    xfer(0, 20'h00001, 1, 0, 0);
    xfer(0, 20'h00002, 1, 0, 1);
    xfer(0, 20'h00004, 2, 0, 0);
    xfer(0, 20'h80000, 6765, 0, 0);
    xfer(0, 20'h40000, 8362, 0, 0);
    xfer(1, 20'h40000, 4181, 0, 0);
    xfer(2, 20'hFFFFF, 21891, 0, 0);
    xfer(3, 20'hFFFFF, 5507, 1, 0);
    xfer(3, 20'h00001, 1, 0, 0);
    xfer(0, 20'h00008, 3, 0, 10);

    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 4; k++)
        xfer_rand(k, 20'($urandom), int'($urandom_range(0, 3)));

    back_to_back();
    mid_reset();
    xfer_rand(0, 20'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
